// File: rtl/tart_ctrl_pkg.sv
// rtl/tart_ctrl_pkg.sv - shared state encoding and defaults for the correlator run controller
package tart_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARM   = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  localparam int DRAIN_MAX_DEF = 4096;

endpackage

// File: rtl/ctrl_timeout.sv
// rtl/ctrl_timeout.sv - loadable down-counter with zero flag
module ctrl_timeout #(
  parameter int WIDTH = 12
) (
  input  logic             clock,
  input  logic             areset_n,
  input  logic             load_i,
  input  logic [WIDTH-1:0] value_i,
  input  logic             enable_i,
  output logic             zero_o
);

  logic [WIDTH-1:0] count_q;

  // Load wins over decrement; the counter parks at zero instead of wrapping.
  always_ff @(posedge clock or negedge areset_n) begin
    if (!areset_n) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= value_i;
    end else if (enable_i && (count_q != '0)) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/vis_scheduler.sv
// rtl/vis_scheduler.sv - run controller for the correlator datapath in the vis clock domain
module vis_scheduler
  import tart_ctrl_pkg::*;
#(
  parameter int CWIDTH    = 26,
  parameter int FWIDTH    = 16,
  parameter int DRAIN_MAX = DRAIN_MAX_DEF
) (
  input  logic              clock,
  input  logic              areset_n,
  input  logic              cfg_start_i,
  input  logic              cfg_stop_i,
  input  logic [CWIDTH-1:0] cfg_count_i,
  input  logic [FWIDTH-1:0] cfg_frames_i,
  input  logic              sig_valid_i,
  input  logic              sig_first_i,
  input  logic              acc_valid_i,
  input  logic              acc_last_i,
  input  logic              acc_ready_i,
  output logic              cor_enable_o,
  output logic [CWIDTH-1:0] acc_count_o,
  output logic              busy_o,
  output logic              start_o,
  output logic              done_o,
  output logic              abort_o,
  output logic              overflow_o,
  output logic [FWIDTH-1:0] frames_o
);

  localparam int TW = (DRAIN_MAX > 1) ? $clog2(DRAIN_MAX) : 1;
  localparam logic [TW-1:0] TLOAD = TW'(DRAIN_MAX - 1);

  state_t            state_q;
  state_t            state_d;
  logic [FWIDTH-1:0] frames_cfg_q;

  logic              last_beat;
  logic              start_ok;
  logic              accept;
  logic [FWIDTH:0]   frames_plus;
  logic              frames_hit;
  logic              timer_zero;
  logic              timer_load;
  logic              drain_abort;

  logic              cor_enable_d;
  logic              busy_d;
  logic              start_d;
  logic              done_d;
  logic              abort_d;
  logic              overflow_d;
  logic [FWIDTH-1:0] frames_d;

  assign last_beat   = acc_valid_i && acc_last_i;
  assign start_ok    = cfg_start_i && (cfg_count_i != '0);
  assign accept      = (state_q == ST_IDLE) && start_ok;
  // One extra bit so the target compare is exact even when frames_o is all-ones.
  assign frames_plus = {1'b0, frames_o} + {{FWIDTH{1'b0}}, 1'b1};
  assign frames_hit  = (frames_cfg_q != '0) && (frames_plus == {1'b0, frames_cfg_q});
  assign timer_load  = (state_q == ST_RUN) && (state_d == ST_DRAIN);
  // A final beat arriving on the timeout cycle still counts as a clean drain.
  assign drain_abort = (state_q == ST_DRAIN) && !last_beat && timer_zero;

  ctrl_timeout #(
    .WIDTH(TW)
  ) u_drain_timer (
    .clock   (clock),
    .areset_n(areset_n),
    .load_i  (timer_load),
    .value_i (TLOAD),
    .enable_i(state_q == ST_DRAIN),
    .zero_o  (timer_zero)
  );

  // State register.
  always_ff @(posedge clock or negedge areset_n) begin
    if (!areset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode; stop has priority over a coincident block boundary in ARM.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start_ok) state_d = ST_ARM;
      ST_ARM: begin
        if (cfg_stop_i) begin
          state_d = ST_IDLE;
        end else if (sig_valid_i && sig_first_i) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (last_beat && (frames_hit || cfg_stop_i)) begin
          state_d = ST_IDLE;
        end else if (cfg_stop_i) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: if (last_beat || timer_zero) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs, derived from the current and next state.
  always_comb begin
    cor_enable_d = (state_d == ST_RUN);
    busy_d       = (state_d != ST_IDLE);
    start_d      = (state_q == ST_ARM) && (state_d == ST_RUN);
    done_d       = (state_q != ST_IDLE) && (state_d == ST_IDLE);

    abort_d = abort_o;
    if ((state_q == ST_IDLE) && cfg_start_i) begin
      abort_d = !start_ok;
    end else if (drain_abort) begin
      abort_d = 1'b1;
    end

    overflow_d = overflow_o;
    if (accept) begin
      overflow_d = 1'b0;
    end else if ((state_q != ST_IDLE) && acc_valid_i && !acc_ready_i) begin
      overflow_d = 1'b1;
    end

    frames_d = frames_o;
    if (accept) begin
      frames_d = '0;
    end else if (((state_q == ST_RUN) || (state_q == ST_DRAIN)) && last_beat && !(&frames_o)) begin
      frames_d = frames_plus[FWIDTH-1:0];
    end
  end

  // Output registers.
  always_ff @(posedge clock or negedge areset_n) begin
    if (!areset_n) begin
      cor_enable_o <= 1'b0;
      busy_o       <= 1'b0;
      start_o      <= 1'b0;
      done_o       <= 1'b0;
      abort_o      <= 1'b0;
      overflow_o   <= 1'b0;
      frames_o     <= '0;
    end else begin
      cor_enable_o <= cor_enable_d;
      busy_o       <= busy_d;
      start_o      <= start_d;
      done_o       <= done_d;
      abort_o      <= abort_d;
      overflow_o   <= overflow_d;
      frames_o     <= frames_d;
    end
  end

  // Configuration latch; only an accepted start may change it.
  always_ff @(posedge clock or negedge areset_n) begin
    if (!areset_n) begin
      acc_count_o  <= '0;
      frames_cfg_q <= '0;
    end else if (accept) begin
      acc_count_o  <= cfg_count_i;
      frames_cfg_q <= cfg_frames_i;
    end
  end

endmodule
